// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
//  Module   : riscv_ctrl_pkg
//  Purpose  : Opcode classes, issue FSM states and helpers for instr_issue_unit
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_BR = 7'b1100011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_LD = 7'b0000011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } issue_state_t;

  function automatic logic is_legal_opc(input logic [6:0] opc);
    logic legal;
    case (opc)
      OPC_R, OPC_BR, OPC_ST, OPC_LD: legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : 1-bit two-flop synchroniser, resets to 0
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/instr_issue_unit.sv
// ============================================================================
//  Module   : instr_issue_unit
//  Purpose  : Instruction FIFO + legal-opcode filter driving a 4-phase set/done
//             handshake. Optional macro ISSUE_STATS_EN adds per-class counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_issue_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  output logic            set,
  output logic [6:0]      opcode,
  input  logic            done,
  output logic            busy,
  output logic            illegal_pulse,
  output logic            err_timeout
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]     cnt_r,
  output logic [15:0]     cnt_br,
  output logic [15:0]     cnt_st,
  output logic [15:0]     cnt_ld,
  output logic [15:0]     cnt_illegal
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // Only the opcode field is ever consumed downstream.
  logic unused_instr_bits;
  assign unused_instr_bits = ^in_instr[XLEN-1:7];

  logic [6:0]    mem_q [DEPTH];
  logic [6:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  issue_state_t  state_q, state_d;
  logic          set_q, set_d;
  logic [6:0]    opcode_q, opcode_d;
  logic          illegal_q, illegal_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic          done_s;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [6:0]    head;
  logic          head_legal;

  sync_2ff u_done_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (done),
    .q       (done_s)
  );

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign push       = in_valid && !full;
  assign pop        = (state_q == IDLE) && !empty;
  assign head       = mem_q[rd_ptr_q];
  assign head_legal = is_legal_opc(head);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_instr[6:0];
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop && head_legal) state_d = REQ;
      REQ:     if (done_s)            state_d = REL;
      REL:     if (!done_s)           state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    set_d     = set_q;
    opcode_d  = opcode_q;
    illegal_d = 1'b0;
    err_d     = err_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          if (head_legal) begin
            set_d     = 1'b1;
            opcode_d  = head;
            tmo_cnt_d = '0;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      REQ:     if (done_s) set_d = 1'b0;
      default: ;
    endcase
    // Timeout only flags a stuck handshake; the FSM keeps waiting regardless.
    if (state_q != IDLE && tmo_cnt_q < TW'(TIMEOUT_CYC)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      set_q     <= 1'b0;
      opcode_q  <= 7'b0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      set_q     <= set_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign in_ready      = !full;
  assign set           = set_q;
  assign opcode        = opcode_q;
  assign busy          = (state_q != IDLE);
  assign illegal_pulse = illegal_q;
  assign err_timeout   = err_q;

`ifdef ISSUE_STATS_EN
  logic [15:0] cnt_r_q,   cnt_r_d;
  logic [15:0] cnt_br_q,  cnt_br_d;
  logic [15:0] cnt_st_q,  cnt_st_d;
  logic [15:0] cnt_ld_q,  cnt_ld_d;
  logic [15:0] cnt_ill_q, cnt_ill_d;

  always_comb begin
    cnt_r_d   = cnt_r_q;
    cnt_br_d  = cnt_br_q;
    cnt_st_d  = cnt_st_q;
    cnt_ld_d  = cnt_ld_q;
    cnt_ill_d = cnt_ill_q;
    if (pop) begin
      case (head)
        OPC_R:   cnt_r_d   = sat_inc16(cnt_r_q);
        OPC_BR:  cnt_br_d  = sat_inc16(cnt_br_q);
        OPC_ST:  cnt_st_d  = sat_inc16(cnt_st_q);
        OPC_LD:  cnt_ld_d  = sat_inc16(cnt_ld_q);
        default: cnt_ill_d = sat_inc16(cnt_ill_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r_q   <= '0;
      cnt_br_q  <= '0;
      cnt_st_q  <= '0;
      cnt_ld_q  <= '0;
      cnt_ill_q <= '0;
    end else begin
      cnt_r_q   <= cnt_r_d;
      cnt_br_q  <= cnt_br_d;
      cnt_st_q  <= cnt_st_d;
      cnt_ld_q  <= cnt_ld_d;
      cnt_ill_q <= cnt_ill_d;
    end
  end

  assign cnt_r       = cnt_r_q;
  assign cnt_br      = cnt_br_q;
  assign cnt_st      = cnt_st_q;
  assign cnt_ld      = cnt_ld_q;
  assign cnt_illegal = cnt_ill_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_issue_unit.sv
// ============================================================================
//  Module   : tb_instr_issue_unit
//  Purpose  : Directed + randomized self-checking bench for instr_issue_unit
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_issue_unit;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int TMO   = 8;

  localparam logic [6:0] C_R  = 7'b0110011;
  localparam logic [6:0] C_BR = 7'b1100011;
  localparam logic [6:0] C_ST = 7'b0100011;
  localparam logic [6:0] C_LD = 7'b0000011;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [XLEN-1:0] in_instr = '0;
  logic            done = 1'b0;
  logic            in_ready;
  logic            set;
  logic [6:0]      opcode;
  logic            busy;
  logic            illegal_pulse;
  logic            err_timeout;
`ifdef ISSUE_STATS_EN
  logic [15:0] cnt_r, cnt_br, cnt_st, cnt_ld, cnt_illegal;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_issue_unit #(.DEPTH(DEPTH), .XLEN(XLEN), .TIMEOUT_CYC(TMO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .set           (set),
    .opcode        (opcode),
    .done          (done),
    .busy          (busy),
    .illegal_pulse (illegal_pulse),
    .err_timeout   (err_timeout)
`ifdef ISSUE_STATS_EN
    ,
    .cnt_r         (cnt_r),
    .cnt_br        (cnt_br),
    .cnt_st        (cnt_st),
    .cnt_ld        (cnt_ld),
    .cnt_illegal   (cnt_illegal)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit legal7(input logic [6:0] o);
    return (o == C_R) || (o == C_BR) || (o == C_ST) || (o == C_LD);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    done     = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic push_one(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_set(input logic val, input string tag);
    int n = 0;
    while (set !== val && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(set), 32'(val));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  // Controller side: acknowledge the request, then release it.
  task automatic hs_finish(input logic [6:0] opc);
    done = 1'b1;
    wait_set(1'b0, "hs_set_low");
    chk("hs_opc_held", 32'(opcode), 32'(opc));
    done = 1'b0;
    wait_idle("hs_idle");
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0] o;
    case ($urandom_range(0, 5))
      0:       o = C_R;
      1:       o = C_BR;
      2:       o = C_ST;
      3:       o = C_LD;
      default: begin
        o = 7'($urandom);
        if (legal7(o)) o = o ^ 7'h04;
      end
    endcase
    return {25'($urandom), o};
  endfunction

  logic [6:0]  exp_q[$];
  logic [6:0]  exp_o;
  logic [6:0]  dir_seq[4];
  logic [6:0]  stat_seq[6];
  logic [31:0] ri;
  logic        prev_set;
  int          cyc;
  int          raise_at;
  int          done_cyc;

  initial begin
    // reset values
    #1;
    tick();
    chk("rst_set", 32'(set), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_illegal", 32'(illegal_pulse), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    // single R-type with exact latencies
    push_one(32'h003100B3);
    chk("r_set_early", 32'(set), 32'd0);
    chk("r_ready", 32'(in_ready), 32'd1);
    tick();
    chk("r_set_rise", 32'(set), 32'd1);
    chk("r_opcode", 32'(opcode), 32'(C_R));
    chk("r_busy", 32'(busy), 32'd1);
    repeat (4) tick();
    done = 1'b1;
    tick();
    tick();
    chk("r_set_m2", 32'(set), 32'd1);
    tick();
    chk("r_set_m3", 32'(set), 32'd0);
    chk("r_busy_rel", 32'(busy), 32'd1);
    done = 1'b0;
    tick();
    tick();
    chk("r_busy_rel2", 32'(busy), 32'd1);
    chk("r_opc_rel", 32'(opcode), 32'(C_R));
    tick();
    chk("r_idle", 32'(busy), 32'd0);

    // async reset while requesting
    push_one(32'h003100B3);
    tick();
    chk("ar_set_before", 32'(set), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("ar_set", 32'(set), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_ready", 32'(in_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("ar_set_after", 32'(set), 32'd0);
    chk("ar_busy_after", 32'(busy), 32'd0);

    // fill FIFO behind a stalled request, then drain in order
    dir_seq[0] = C_BR; dir_seq[1] = C_BR; dir_seq[2] = C_ST; dir_seq[3] = C_LD;
    push_one({25'h0, C_R});
    tick();
    chk("fill_set", 32'(set), 32'd1);
    for (int i = 0; i < 4; i++) push_one({25'h1234, dir_seq[i]});
    chk("fill_full", 32'(in_ready), 32'd0);
    push_one({25'h0, 7'b0010011});
    chk("fill_still_full", 32'(in_ready), 32'd0);
    chk("fill_opc_r", 32'(opcode), 32'(C_R));
    hs_finish(C_R);
    for (int i = 0; i < 4; i++) begin
      wait_set(1'b1, "fill_set_rise");
      chk("fill_order", 32'(opcode), 32'(dir_seq[i]));
      hs_finish(dir_seq[i]);
    end
    repeat (3) tick();
    chk("fill_no_extra", 32'(set), 32'd0);

    // illegal drop followed by LD
    do_reset();
    in_valid = 1'b1;
    in_instr = 32'h00000013;
    tick();
    in_instr = 32'h00002083;
    tick();
    in_valid = 1'b0;
    chk("ill_pulse", 32'(illegal_pulse), 32'd1);
    chk("ill_set", 32'(set), 32'd0);
    tick();
    chk("ill_pulse_end", 32'(illegal_pulse), 32'd0);
    chk("ill_ld_set", 32'(set), 32'd1);
    chk("ill_ld_opc", 32'(opcode), 32'(C_LD));
    hs_finish(C_LD);

    // handshake timeout
    do_reset();
    push_one({25'h0, C_R});
    tick();
    chk("tmo_set", 32'(set), 32'd1);
    repeat (TMO - 1) tick();
    chk("tmo_err_pre", 32'(err_timeout), 32'd0);
    tick();
    chk("tmo_err", 32'(err_timeout), 32'd1);
    chk("tmo_set_held", 32'(set), 32'd1);
    hs_finish(C_R);
    chk("tmo_err_sticky", 32'(err_timeout), 32'd1);

`ifdef ISSUE_STATS_EN
    do_reset();
    stat_seq[0] = C_R; stat_seq[1] = C_LD; stat_seq[2] = 7'b0010011;
    stat_seq[3] = C_R; stat_seq[4] = C_LD; stat_seq[5] = C_R;
    for (int i = 0; i < 6; i++) begin
      push_one({25'h0, stat_seq[i]});
      if (legal7(stat_seq[i])) begin
        wait_set(1'b1, "st_set");
        hs_finish(stat_seq[i]);
      end else begin
        tick();
        tick();
      end
    end
    chk("st_r", 32'(cnt_r), 32'd3);
    chk("st_ld", 32'(cnt_ld), 32'd2);
    chk("st_ill", 32'(cnt_illegal), 32'd1);
    chk("st_br", 32'(cnt_br), 32'd0);
    chk("st_st", 32'(cnt_st), 32'd0);
`endif

    // randomized traffic against an in-order issue model
    do_reset();
    prev_set = 1'b0;
    cyc      = 0;
    raise_at = -1;
    done_cyc = 0;
    while (cyc < 500 || ((exp_q.size() != 0 || busy) && cyc < 3000)) begin
      if (set && !prev_set) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious_issue", 32'd1, 32'd0);
        end else begin
          exp_o = exp_q.pop_front();
          chk("rnd_issue", {24'd0, 1'b1, opcode}, {24'd0, legal7(exp_o), exp_o});
        end
        raise_at = cyc + int'($urandom_range(0, 1));
      end
      if (illegal_pulse) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious_drop", 32'd1, 32'd0);
        end else begin
          exp_o = exp_q.pop_front();
          chk("rnd_drop_illegal", 32'(legal7(exp_o)), 32'd0);
        end
      end
      if (!set && prev_set) chk("rnd_fall_lat", 32'(cyc - done_cyc), 32'd3);
      if (set && !done && cyc == raise_at) begin
        done     = 1'b1;
        done_cyc = cyc;
      end
      if (!set && done) done = 1'b0;
      prev_set = set;
      in_valid = (cyc < 500) && ($urandom_range(0, 2) != 0);
      ri       = gen_instr();
      in_instr = ri;
      if (in_valid && in_ready) exp_q.push_back(ri[6:0]);
      tick();
      cyc++;
    end
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);
    chk("rnd_busy", 32'(busy), 32'd0);
    chk("rnd_err", 32'(err_timeout), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
